// File: rtl/dmx_rx.sv
// DMX512 receiver: break/MAB/slot decoder feeding a 512x8 channel RAM, with CSR read-back.
// Optional frame-done interrupt output when DMX_RX_IRQ_EN is defined.
module dmx_rx #(
    parameter logic [4:0]  csr_addr = 5'h0,
    parameter int unsigned clk_freq = 100000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [14:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    input  logic        rx
`ifdef DMX_RX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int unsigned DIV     = clk_freq / 250000;
    localparam int unsigned HALF    = DIV / 2;
    localparam int unsigned BRK_CYC = 22 * DIV;
    localparam int unsigned LW      = $clog2(BRK_CYC + 1);

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_BREAK = 3'd1;
    localparam logic [2:0] S_MAB   = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_IDLE  = 3'd6;

    logic          rx_m, rxs, rxs_d;
    logic [LW-1:0] low_cnt;
    logic          brk;
    logic [8:0]    tmr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [2:0]    state, state_nxt;
    logic          have_sc;
    logic [7:0]    sc_cur;
    logic [9:0]    slot_cnt;
    logic          en;
    logic [9:0]    last_count;
    logic [7:0]    last_sc;
    logic [31:0]   frame_cnt;
    logic [7:0]    ram [512];

    logic       fall_c, tick_c, ld_half_c, ld_full_c, shift_c, commit_c;
    logic       frame_end_c, abort_c, ram_we_c, sel_c, reg_we_c;
    logic [9:0] end_count_c;
    logic       unused_di;

    assign unused_di = ^csr_di[31:1];
    assign fall_c    = rxs_d & ~rxs;
    assign tick_c    = (tmr == 9'd0);
    assign ram_we_c  = commit_c & have_sc & (sc_cur == 8'd0);
    assign sel_c     = (csr_a[14:10] == csr_addr);
    assign reg_we_c  = sel_c & csr_we & csr_a[9];

    // Synchronizer, edge history and break detector
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_m    <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            low_cnt <= '0;
            brk     <= 1'b0;
        end else begin
            rx_m  <= rx;
            rxs   <= rx_m;
            rxs_d <= rxs;
            brk   <= ~rxs & (low_cnt == LW'(BRK_CYC - 1));
            if (rxs)
                low_cnt <= '0;
            else if (low_cnt != LW'(BRK_CYC))
                low_cnt <= low_cnt + LW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= S_WAIT;
        else
            state <= state_nxt;
    end

    // Next state and per-cycle datapath controls
    always_comb begin
        state_nxt   = state;
        ld_half_c   = 1'b0;
        ld_full_c   = 1'b0;
        shift_c     = 1'b0;
        commit_c    = 1'b0;
        frame_end_c = 1'b0;
        abort_c     = 1'b0;
        end_count_c = slot_cnt;
        if (!en) begin
            state_nxt = S_WAIT;
            abort_c   = 1'b1;
        end else if (brk) begin
            state_nxt   = S_BREAK;
            frame_end_c = have_sc;
            abort_c     = 1'b1;
        end else begin
            case (state)
                S_BREAK: if (rxs) state_nxt = S_MAB;
                S_MAB, S_IDLE: begin
                    if (fall_c) begin
                        state_nxt = S_START;
                        ld_half_c = 1'b1;
                    end
                end
                S_START: begin
                    if (tick_c) begin
                        if (rxs) begin
                            state_nxt = have_sc ? S_IDLE : S_MAB;
                        end else begin
                            state_nxt = S_DATA;
                            ld_full_c = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick_c) begin
                        shift_c   = 1'b1;
                        ld_full_c = 1'b1;
                        if (bit_cnt == 3'd7) state_nxt = S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick_c) begin
                        if (rxs) begin
                            commit_c  = 1'b1;
                            state_nxt = S_IDLE;
                            if (have_sc && slot_cnt == 10'd511) begin
                                frame_end_c = 1'b1;
                                abort_c     = 1'b1;
                                end_count_c = 10'd512;
                                state_nxt   = S_WAIT;
                            end
                        end else begin
                            state_nxt = S_WAIT;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Bit timer, shifter, slot bookkeeping and status registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmr        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            have_sc    <= 1'b0;
            sc_cur     <= '0;
            slot_cnt   <= '0;
            en         <= 1'b0;
            last_count <= '0;
            last_sc    <= '0;
            frame_cnt  <= '0;
        end else begin
            if (ld_half_c)
                tmr <= 9'(HALF - 1);
            else if (ld_full_c)
                tmr <= 9'(DIV - 1);
            else if (!tick_c)
                tmr <= tmr - 9'd1;

            if (ld_half_c)
                bit_cnt <= '0;
            else if (shift_c)
                bit_cnt <= bit_cnt + 3'd1;
            if (shift_c)
                shreg <= {rxs, shreg[7:1]};

            if (commit_c && !have_sc) begin
                sc_cur  <= shreg;
                have_sc <= 1'b1;
            end else if (commit_c) begin
                slot_cnt <= slot_cnt + 10'd1;
            end
            if (abort_c) begin
                have_sc  <= 1'b0;
                slot_cnt <= '0;
            end

            if (frame_end_c) begin
                last_count <= end_count_c;
                last_sc    <= sc_cur;
            end
            if (reg_we_c && csr_a[1:0] == 2'd3)
                frame_cnt <= '0;
            else if (frame_end_c)
                frame_cnt <= frame_cnt + 32'd1;

            if (reg_we_c && csr_a[1:0] == 2'd0)
                en <= csr_di[0];
        end
    end

`ifdef DMX_RX_IRQ_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            irq <= 1'b0;
        else
            irq <= frame_end_c;
    end
`endif

    // Channel RAM write port; the CSR port below reads the pre-write byte
    always_ff @(posedge sys_clk) begin
        if (ram_we_c)
            ram[slot_cnt[8:0]] <= shreg;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csr_do <= '0;
        end else if (!sel_c) begin
            csr_do <= '0;
        end else if (!csr_a[9]) begin
            csr_do <= {24'd0, ram[csr_a[8:0]]};
        end else begin
            case (csr_a[1:0])
                2'd0:    csr_do <= {31'd0, en};
                2'd1:    csr_do <= {22'd0, last_count};
                2'd2:    csr_do <= {24'd0, last_sc};
                default: csr_do <= frame_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_dmx_rx.sv
// Directed bench for dmx_rx: drives DMX frames on rx and checks RAM/status through CSR reads.
// Uses a reduced clock frequency so one bit time is 8 cycles.
module tb_dmx_rx;
    localparam int unsigned CLK_FREQ = 2000000;
    localparam int unsigned DIV      = CLK_FREQ / 250000;
    localparam int unsigned BRK      = 22 * DIV;
    localparam logic [14:0] PARK     = 15'h7C00;
    localparam logic [14:0] REG      = 15'h0200;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [14:0] csr_a = PARK;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic        rx = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

`ifdef DMX_RX_IRQ_EN
    logic irq;
    int   irq_cnt = 0;
    int   irq_run = 0;
    int   irq_max = 0;
    always @(posedge sys_clk) begin
        if (irq) begin
            irq_cnt <= irq_cnt + 1;
            irq_run <= irq_run + 1;
            if (irq_run + 1 > irq_max) irq_max <= irq_run + 1;
        end else begin
            irq_run <= 0;
        end
    end
`endif

    dmx_rx #(.csr_addr(5'h0), .clk_freq(CLK_FREQ)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_di   (csr_di),
        .csr_do   (csr_do),
        .rx       (rx)
`ifdef DMX_RX_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic line(input logic v, input int cyc);
        @(negedge sys_clk);
        rx = v;
        repeat (cyc - 1) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line(1'b0, DIV);
        for (int i = 0; i < 8; i++) line(b[i], DIV);
        line(stop, DIV);
        line(1'b1, DIV);
    endtask

    task automatic send_break();
        line(1'b0, 25 * DIV);
        line(1'b1, 3 * DIV);
    endtask

    task automatic csr_wr(input logic [14:0] addr, input logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = addr;
        csr_di = data;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = PARK;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] e);
        n_assert++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    // Expected value queued at issue, popped when the registered read data appears
    task automatic check_rd(input string tag, input logic [14:0] addr, input logic [31:0] e);
        logic [31:0] got;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge sys_clk);
        csr_a = addr;
        @(negedge sys_clk);
        got   = csr_do;
        csr_a = PARK;
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("csr_do_in_reset", csr_do, 32'h0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("csr_do_idle", csr_do, 32'h0);
        check_rd("ctrl_rst", REG + 15'd0, 32'h0);
        check_rd("last_count_rst", REG + 15'd1, 32'h0);
        check_rd("last_sc_rst", REG + 15'd2, 32'h0);
        check_rd("frame_cnt_rst", REG + 15'd3, 32'h0);

        csr_wr(REG + 15'd0, 32'h1);
        check_rd("ctrl_en", REG + 15'd0, 32'h1);
        line(1'b1, 4 * DIV);

        // Short frame closed by a break
        send_break();
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_break();
        check_rd("f1_ram0", 15'd0, 32'h11);
        check_rd("f1_ram1", 15'd1, 32'h22);
        check_rd("f1_ram2", 15'd2, 32'h33);
        check_rd("f1_last_count", REG + 15'd1, 32'd3);
        check_rd("f1_last_sc", REG + 15'd2, 32'h0);
        check_rd("f1_frame_cnt", REG + 15'd3, 32'd1);
`ifdef DMX_RX_IRQ_EN
        check("f1_irq_cnt", 32'(irq_cnt), 32'd1);
        check("f1_irq_width", 32'(irq_max), 32'd1);
`endif

        // Full 512-slot frame ends without a break
        send_break();
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
        check_rd("full_frame_cnt", REG + 15'd3, 32'd2);
        check_rd("full_last_count", REG + 15'd1, 32'd512);
        check_rd("full_ram511", 15'd511, 32'hFF);
        check_rd("full_ram0", 15'd0, 32'h00);
        check_rd("full_ram300", 15'd300, 32'h2C);

        // Non-zero start code leaves the RAM alone
        send_break();
        send_byte(8'hCC, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        send_break();
        check_rd("sc_last_sc", REG + 15'd2, 32'hCC);
        check_rd("sc_last_count", REG + 15'd1, 32'd5);
        check_rd("sc_ram0", 15'd0, 32'h00);
        check_rd("sc_ram4", 15'd4, 32'h04);
        check_rd("sc_frame_cnt", REG + 15'd3, 32'd3);

        // Framing error, then a sub-threshold low and an ignored byte
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b0);
        line(1'b1, 2 * DIV);
        line(1'b0, 15 * DIV);
        line(1'b1, 3 * DIV);
        send_byte(8'h99, 1'b1);
        check_rd("fe_no_false_brk", REG + 15'd3, 32'd3);
        send_break();
        check_rd("fe_frame_cnt", REG + 15'd3, 32'd4);
        check_rd("fe_last_count", REG + 15'd1, 32'd2);
        check_rd("fe_ram1", 15'd1, 32'h66);
        check_rd("fe_ram2_kept", 15'd2, 32'h02);
        check_rd("fe_ram3_kept", 15'd3, 32'h03);

        // Short glitch between slots is rejected
        send_byte(8'h00, 1'b1);
        send_byte(8'hAB, 1'b1);
        line(1'b0, 2);
        line(1'b1, 2 * DIV);
        send_byte(8'hCD, 1'b1);
        send_break();
        check_rd("gl_last_count", REG + 15'd1, 32'd2);
        check_rd("gl_ram0", 15'd0, 32'hAB);
        check_rd("gl_ram1", 15'd1, 32'hCD);
        check_rd("gl_frame_cnt", REG + 15'd3, 32'd5);

        // FRAME_CNT clear lands in the same cycle as the break-driven frame end
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        @(negedge sys_clk);
        rx = 1'b0;
        repeat (BRK + 2) @(negedge sys_clk);
        csr_a  = REG + 15'd3;
        csr_di = 32'h0;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = PARK;
        repeat (25 * DIV - BRK - 3) @(negedge sys_clk);
        line(1'b1, 3 * DIV);
        check_rd("clr_frame_cnt", REG + 15'd3, 32'd0);
        check_rd("clr_last_count", REG + 15'd1, 32'd1);

        // Disabling mid-frame aborts without an event
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        csr_wr(REG + 15'd0, 32'h0);
        check_rd("dis_ctrl", REG + 15'd0, 32'h0);
        csr_wr(REG + 15'd0, 32'h1);
        send_break();
        check_rd("dis_frame_cnt", REG + 15'd3, 32'd0);
        check_rd("dis_last_count", REG + 15'd1, 32'd1);
        check_rd("dis_ram0", 15'd0, 32'h01);
`ifdef DMX_RX_IRQ_EN
        check("end_irq_cnt", 32'(irq_cnt), 32'd6);
        check("end_irq_width", 32'(irq_max), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
